// File: rtl/cussen_pkg.sv
// cussen_pkg
// Shared constants, element types and the decoder FSM state type for the
// cussen sort/dedup/delta frame decoder.
// Bus helpers pull element k out of the packed frame buses. An index past the
// last element yields a not-found pointer or a zero delta, so callers never
// read beyond the bus.
package cussen_pkg;

    localparam int N_ELEM = 9;
    localparam int DATA_W = 8;
    localparam int PTR_W  = 4;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [PTR_W-1:0]  ptr_t;

    localparam ptr_t PTR_NONE = 4'hF;
    localparam ptr_t LAST_IDX = 4'(N_ELEM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        EMIT  = 2'd2
    } state_t;

    function automatic logic ptr_in_range(input ptr_t p);
        return p <= LAST_IDX;
    endfunction

    function automatic ptr_t ptr_at(input logic [N_ELEM*PTR_W-1:0] bus, input ptr_t idx);
        if (idx > LAST_IDX) begin
            return PTR_NONE;
        end
        return bus[idx*PTR_W +: PTR_W];
    endfunction

    function automatic data_t delta_at(input logic [N_ELEM*DATA_W-1:0] bus, input ptr_t idx);
        if (idx > LAST_IDX) begin
            return '0;
        end
        return bus[idx*DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/cussen_decoder_if.sv
// cussen_decoder_if
// Groups the frame-input handshake and the byte-output stream of the decoder.
//   in_valid / in_ready   : frame handshake
//   delta_bus  [71:0]     : nine 8-bit successive differences, element k at [8k+7:8k]
//   ptr_bus    [35:0]     : nine 4-bit table pointers, pointer k at [4k+3:4k]
//   out_valid / out_ready : byte-stream handshake
//   out_data, out_index, out_last, out_err : current output byte and its tags
//   err_count  [7:0]      : saturating count of error bytes since reset
// master: frame source and byte sink. slave: the decoder.
interface cussen_decoder_if import cussen_pkg::*; ();

    logic                     in_valid;
    logic                     in_ready;
    logic [N_ELEM*DATA_W-1:0] delta_bus;
    logic [N_ELEM*PTR_W-1:0]  ptr_bus;
    logic                     out_valid;
    logic                     out_ready;
    data_t                    out_data;
    ptr_t                     out_index;
    logic                     out_last;
    logic                     out_err;
    logic [7:0]               err_count;

    modport master (
        output in_valid, delta_bus, ptr_bus, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last, out_err, err_count
    );

    modport slave (
        input  in_valid, delta_bus, ptr_bus, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last, out_err, err_count
    );

endinterface

// File: rtl/cussen_decode_table.sv
// cussen_decode_table
// 9 x 8-bit sorted-unique table, rebuilt by prefix sum.
//   clk, rst  : clock, async active-high reset (clears every entry)
//   wr_en     : write entry wr_addr this cycle
//   wr_addr   : entry being written (0..8)
//   wr_delta  : successive difference for that entry
//   wr_value  : value being written (also used by the caller to bypass a
//               same-cycle read)
//   rd_addr   : combinational read address; out-of-range reads return 0
//   rd_data   : entry at rd_addr
// Entry 0 takes the delta as an absolute value. Later entries add the delta to
// the previous entry modulo 256, except that a zero delta marks a padding slot,
// which stores 0.
module cussen_decode_table import cussen_pkg::*; (
    input  logic  clk,
    input  logic  rst,
    input  logic  wr_en,
    input  ptr_t  wr_addr,
    input  data_t wr_delta,
    output data_t wr_value,
    input  ptr_t  rd_addr,
    output data_t rd_data
);

    data_t tbl_q [N_ELEM];
    data_t tbl_d [N_ELEM];
    data_t prev_entry;

    assign prev_entry = (wr_addr == '0 || wr_addr > LAST_IDX) ? '0 : tbl_q[4'(wr_addr - 4'd1)];

    always_comb begin
        wr_value = prev_entry + wr_delta;
        if (wr_addr == '0) begin
            wr_value = wr_delta;
        end else if (wr_delta == '0) begin
            wr_value = '0;
        end
    end

    always_comb begin
        tbl_d = tbl_q;
        if (wr_en && wr_addr <= LAST_IDX) begin
            tbl_d[wr_addr] = wr_value;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl_q <= '{default: '0};
        end else begin
            tbl_q <= tbl_d;
        end
    end

    assign rd_data = (rd_addr <= LAST_IDX) ? tbl_q[rd_addr] : '0;

endmodule

// File: rtl/cussen_decoder.sv
// cussen_decoder
// Rebuilds nine original bytes from one encoded frame: prefix-sums the deltas
// into the sorted-unique table, then streams out table[ptr[j]] for j = 0..8.
//   clk  : rising-edge clock
//   rst  : async active-high reset; aborts any frame in flight
//   bus  : cussen_decoder_if.slave (frame input, byte output, err_count)
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | in_ready high; waits for a frame transfer and captures both buses
// BUILD | writes table entry build_k (0..8), one per cycle
// EMIT  | presents byte out_index (0..8); advances on each out handshake
module cussen_decoder import cussen_pkg::*; (
    input  logic             clk,
    input  logic             rst,
    cussen_decoder_if.slave  bus
);

    state_t                   state_q,     state_d;
    logic [N_ELEM*DATA_W-1:0] delta_q,     delta_d;
    logic [N_ELEM*PTR_W-1:0]  ptr_q,       ptr_d;
    ptr_t                     build_k_q,   build_k_d;
    logic                     out_valid_q, out_valid_d;
    data_t                    out_data_q,  out_data_d;
    ptr_t                     out_index_q, out_index_d;
    logic                     out_last_q,  out_last_d;
    logic                     out_err_q,   out_err_d;
    logic [7:0]               err_count_q, err_count_d;

    logic  tbl_wr_en;
    data_t tbl_wr_value;
    data_t tbl_rd_data;
    ptr_t  emit_idx;
    ptr_t  rd_addr;
    data_t rd_val;
    logic  nxt_err;
    data_t nxt_data;

    assign tbl_wr_en = (state_q == BUILD);

    // Byte to be loaded into the output registers next: byte 0 when leaving
    // BUILD, otherwise the one after the byte currently presented.
    assign emit_idx = (state_q == EMIT) ? 4'(out_index_q + 4'd1) : '0;
    assign rd_addr  = ptr_at(ptr_q, emit_idx);

    // Byte 0 is loaded on the same edge that writes entry 8, so a pointer to
    // entry 8 must see the value being written rather than the stale entry.
    assign rd_val   = (tbl_wr_en && rd_addr == build_k_q) ? tbl_wr_value : tbl_rd_data;
    assign nxt_err  = !ptr_in_range(rd_addr);
    assign nxt_data = nxt_err ? '0 : rd_val;

    cussen_decode_table u_table (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (tbl_wr_en),
        .wr_addr  (build_k_q),
        .wr_delta (delta_at(delta_q, build_k_q)),
        .wr_value (tbl_wr_value),
        .rd_addr  (rd_addr),
        .rd_data  (tbl_rd_data)
    );

    always_comb begin
        state_d     = state_q;
        delta_d     = delta_q;
        ptr_d       = ptr_q;
        build_k_d   = build_k_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        out_err_d   = out_err_q;
        err_count_d = err_count_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    delta_d   = bus.delta_bus;
                    ptr_d     = bus.ptr_bus;
                    build_k_d = '0;
                    state_d   = BUILD;
                end
            end
            BUILD: begin
                if (build_k_q == LAST_IDX) begin
                    state_d     = EMIT;
                    out_valid_d = 1'b1;
                    out_index_d = emit_idx;
                    out_last_d  = (emit_idx == LAST_IDX);
                    out_err_d   = nxt_err;
                    out_data_d  = nxt_data;
                end else begin
                    build_k_d = build_k_q + 4'd1;
                end
            end
            EMIT: begin
                if (out_valid_q && bus.out_ready) begin
                    if (out_err_q && err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                    if (out_last_q) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        out_index_d = '0;
                        out_last_d  = 1'b0;
                        out_err_d   = 1'b0;
                    end else begin
                        out_index_d = emit_idx;
                        out_last_d  = (emit_idx == LAST_IDX);
                        out_err_d   = nxt_err;
                        out_data_d  = nxt_data;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            delta_q     <= '0;
            ptr_q       <= '0;
            build_k_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            delta_q     <= delta_d;
            ptr_q       <= ptr_d;
            build_k_q   <= build_k_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            out_err_q   <= out_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_index = out_index_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_err   = out_err_q;
    assign bus.err_count = err_count_q;

endmodule
